// File: rtl/gate_input_debounce.sv
// Two-channel switch debouncer feeding a downstream gate: each raw level is
// synchronized, then must disagree with the output for STABLE_CYCLES edges in a row before it is accepted.

module gate_input_debounce_chan #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             raw,
    output logic             level,
    output logic             chg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    assign mismatch = (s2 != level);
    assign expire   = mismatch && (cnt == CNT_LAST);

    // cnt tracks the current mismatch run; it clears on agreement or acceptance, so it never passes CNT_LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            chg   <= 1'b0;
        end else begin
            chg <= expire;
            if (!mismatch || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (expire) begin
                level <= s2;
            end
        end
    end

endmodule

module gate_input_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_chg,
    output logic b_chg
);

    if (STABLE_CYCLES < 2 || 64'(STABLE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_params
        $error("gate_input_debounce: STABLE_CYCLES must be in [2, 2**CNT_W]");
    end

    gate_input_debounce_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (a_raw),
        .level (a),
        .chg   (a_chg)
    );

    gate_input_debounce_chan #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (b_raw),
        .level (b),
        .chg   (b_chg)
    );

endmodule

// File: tb/tb_gate_input_debounce.sv
// Bench for gate_input_debounce: directed scenarios plus randomized switch bounce,
// checked against a sample-history model of the two channels.

module tb_gate_input_debounce;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic a_chg;
    logic b_chg;

    int n_checks;
    int n_fail;

    gate_input_debounce dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_raw (a_raw),
        .b_raw (b_raw),
        .a     (a),
        .b     (b),
        .a_chg (a_chg),
        .b_chg (b_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the synchronized samples seen since the last accepted change; a channel
    // accepts a new level once its most recent N samples all disagree with the output.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_out [2];
    bit m_chg [2];
    bit hq_a [$];
    bit hq_b [$];

    function automatic int trail_mismatch(input bit q[$], input bit lvl);
        int run = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i] == lvl) break;
            run++;
        end
        return run;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_chg[c] = 0;
        end
        hq_a.delete();
        hq_b.delete();
    endtask

    task automatic model_step(input bit ra, input bit rb);
        hq_a.push_back(m_s2[0]);
        if (hq_a.size() > N) void'(hq_a.pop_front());
        hq_b.push_back(m_s2[1]);
        if (hq_b.size() > N) void'(hq_b.pop_front());
        m_chg[0] = 0;
        m_chg[1] = 0;
        if (trail_mismatch(hq_a, m_out[0]) >= N) begin
            m_out[0] = m_s2[0]; m_chg[0] = 1; hq_a.delete();
        end
        if (trail_mismatch(hq_b, m_out[1]) >= N) begin
            m_out[1] = m_s2[1]; m_chg[1] = 1; hq_b.delete();
        end
        m_s2[0] = m_s1[0]; m_s1[0] = ra;
        m_s2[1] = m_s1[1]; m_s1[1] = rb;
    endtask

    // Drive raws away from the edge, take one rising edge, then settle 1 time unit before sampling
    task automatic step(input bit ra, input bit rb);
        a_raw = ra;
        b_raw = rb;
        @(posedge clk);
        model_step(ra, rb);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] cnt_a, cnt_b;
        rst_n = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        cnt_a = dut.u_chan_a.cnt;
        cnt_b = dut.u_chan_b.cnt;
        n_checks++;
        if ({a, b, a_chg, b_chg} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected 0000", {a, b, a_chg, b_chg});
        end
        n_checks++;
        if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_cnt: got a=%0d b=%0d expected 0", cnt_a, cnt_b);
        end
        n_checks++;
        if ({dut.u_chan_a.s2, dut.u_chan_b.s2} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_sync: got %b expected 00", {dut.u_chan_a.s2, dut.u_chan_b.s2});
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        bit pat [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            step(pat[k], 1'b0);
            n_checks++;
            if ({a, a_chg} !== 2'b00 || {a, a_chg} !== {m_out[0], m_chg[0]}) begin
                n_fail++;
                $display("[TB] FAIL glitch cycle %0d: got a=%b a_chg=%b expected 0 0", k, a, a_chg);
            end
        end
        n_checks++;
        if (dut.u_chan_a.cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL glitch_cnt: got %0d expected 0", dut.u_chan_a.cnt);
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp_v;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            exp_v = {(k >= 5) ? 1'b1 : 1'b0, 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0};
            n_checks++;
            if ({a, b, a_chg, b_chg} !== exp_v ||
                {a, b, a_chg, b_chg} !== {m_out[0], m_out[1], m_chg[0], m_chg[1]}) begin
                n_fail++;
                $display("[TB] FAIL latency E%0d: got a,b,a_chg,b_chg=%b expected %b", k, {a, b, a_chg, b_chg}, exp_v);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_v;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1);
            exp_v = (k < 5) ? 4'b1000 : ((k == 5) ? 4'b0111 : 4'b0100);
            n_checks++;
            if ({a, b, a_chg, b_chg} !== exp_v ||
                {a, b, a_chg, b_chg} !== {m_out[0], m_out[1], m_chg[0], m_chg[1]}) begin
                n_fail++;
                $display("[TB] FAIL simultaneous E%0d: got a,b,a_chg,b_chg=%b expected %b", k, {a, b, a_chg, b_chg}, exp_v);
            end
        end
    endtask

    task automatic test_reset_midcount();
        bit reached = 0;
        int pulses = 0;
        for (int k = 0; k < 20 && !reached; k++) begin
            step(1'b1, 1'b1);
            if (trail_mismatch(hq_a, m_out[0]) == 2) reached = 1;
        end
        n_checks++;
        if (!reached || dut.u_chan_a.cnt !== 16'd2) begin
            n_fail++;
            $display("[TB] FAIL midcount_setup: got cnt=%0d expected 2 within 20 cycles", dut.u_chan_a.cnt);
        end
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({a, a_chg, b, b_chg} !== 4'b0000 || dut.u_chan_a.cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL midcount_reset: got a,a_chg,b,b_chg=%b cnt=%0d expected 0000 0", {a, a_chg, b, b_chg}, dut.u_chan_a.cnt);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b1);
            pulses += a_chg;
            n_checks++;
            if (a !== ((k >= 5) ? 1'b1 : 1'b0) || a_chg !== ((k == 5) ? 1'b1 : 1'b0) ||
                {a, b, a_chg, b_chg} !== {m_out[0], m_out[1], m_chg[0], m_chg[1]}) begin
                n_fail++;
                $display("[TB] FAIL post_reset E%0d: got a=%b a_chg=%b b=%b b_chg=%b", k, a, a_chg, b, b_chg);
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_toggle();
        logic start_a;
        bit ra;
        start_a = a;
        ra = ~start_a;
        for (int k = 0; k < 50; k++) begin
            step(ra, b);
            ra = ~ra;
            n_checks++;
            if (a !== start_a || a_chg !== 1'b0 || a !== m_out[0]) begin
                n_fail++;
                $display("[TB] FAIL toggle cycle %0d: got a=%b a_chg=%b expected a=%b a_chg=0", k, a, a_chg, start_a);
            end
        end
    endtask

    task automatic test_random();
        bit ra, rb;
        int run_a = 0;
        int run_b = 0;
        logic [15:0] exp_ca, exp_cb;
        ra = a_raw;
        rb = b_raw;
        for (int k = 0; k < 400; k++) begin
            if (run_a == 0) begin ra = ~ra; run_a = $urandom_range(1, 8); end
            if (run_b == 0) begin rb = ~rb; run_b = $urandom_range(1, 8); end
            run_a--;
            run_b--;
            step(ra, rb);
            exp_ca = 16'(trail_mismatch(hq_a, m_out[0]));
            exp_cb = 16'(trail_mismatch(hq_b, m_out[1]));
            n_checks++;
            if ({a, b, a_chg, b_chg} !== {m_out[0], m_out[1], m_chg[0], m_chg[1]} ||
                dut.u_chan_a.cnt !== exp_ca || dut.u_chan_b.cnt !== exp_cb) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d: got a,b,a_chg,b_chg=%b cnt=%0d/%0d expected %b cnt=%0d/%0d",
                         k, {a, b, a_chg, b_chg}, dut.u_chan_a.cnt, dut.u_chan_b.cnt,
                         {m_out[0], m_out[1], m_chg[0], m_chg[1]}, exp_ca, exp_cb);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_glitch();
        test_latency();
        test_simultaneous();
        test_reset_midcount();
        test_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule

// File: doc/gate_input_debounce.md
GATE_INPUT_DEBOUNCE -- requirements
Module: gate_input_debounce

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive clock edges a synchronized input must differ from its output before the output updates.
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of each per-channel stability counter.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port a_raw  input  1  raw, asynchronous switch level for channel A.
REQ-006 Port b_raw  input  1  raw, asynchronous switch level for channel B.
REQ-007 Port a  output  1  debounced level of channel A; drives the downstream gate input a.
REQ-008 Port b  output  1  debounced level of channel B; drives the downstream gate input b.
REQ-009 Port a_chg  output  1  one-cycle pulse on the cycle a takes a new value.
REQ-010 Port b_chg  output  1  one-cycle pulse on the cycle b takes a new value.
REQ-011 The block SHALL use one clock; the reset SHALL be asynchronous and active-low.

Function
REQ-012 Each channel SHALL pass its raw input through a two-flop synchronizer (s1, then s2) before any other use.
REQ-013 Each channel SHALL hold a CNT_W-bit counter cnt, a registered output level, and a registered change pulse; channels SHALL be fully independent.
REQ-014 At each rising edge where s2 equals the output, cnt SHALL load 0 and the output SHALL hold.
REQ-015 At each rising edge where s2 differs from the output and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1 and the output SHALL hold.
REQ-016 At each rising edge where s2 differs from the output and cnt == STABLE_CYCLES-1:
- the output SHALL load s2;
- cnt SHALL load 0;
- the channel's chg SHALL be 1 for exactly the following cycle.
REQ-017 chg SHALL be 0 on every cycle not selected by REQ-016.
REQ-018 Latency: a raw level that changes before rising edge E0 and stays stable SHALL appear on the output after edge E0+STABLE_CYCLES+1, with chg high in the same cycle.
REQ-019 Glitch rejection: if s2 returns to the output level before cnt reaches STABLE_CYCLES-1, cnt SHALL clear and the output and chg SHALL remain unchanged.
REQ-020 Any mismatch run shorter than STABLE_CYCLES edges SHALL never change the output.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1, so no wrap-around is possible.
REQ-022 STABLE_CYCLES SHALL be >= 2 and <= 2^CNT_W.
- Illegal values SHALL be flagged by an elaboration-time check.
REQ-023 Simultaneous qualification on both channels SHALL update a and b on the same edge, with a_chg and b_chg both high in the same cycle.

Reset
REQ-024 While rst_n is 0, the following SHALL all be forced to 0 immediately, independent of clk:
- s1, s2, cnt, a, b, a_chg, b_chg.
REQ-025 Reset asserted mid-count SHALL discard the partial count and produce no chg pulse.
REQ-026 After rst_n deasserts, the first rising edge SHALL perform normal synchronizer and counter operation; an input held at 1 through reset SHALL reach the output after STABLE_CYCLES+1 edges.

Verification (STABLE_CYCLES=4)
REQ-027 Reset, then a_raw=1 set before edge E0 and held -> a=0 through E4, a=1 and a_chg=1 after E5, a_chg=0 after E6; b, b_chg stay 0.
REQ-028 a=0, then a_raw=1 for 2 cycles, then 0 -> a stays 0, a_chg never pulses, cnt returns to 0.
REQ-029 a=1, b=0, then a_raw=0 and b_raw=1 set before the same edge E0 -> after E5: a=0, b=1, a_chg=1 and b_chg=1 together.
REQ-030 a_raw=1 held and cnt=2 on channel A, then rst_n pulsed low for 1 cycle asynchronously -> a, cnt, a_chg read 0 during reset; a rises only STABLE_CYCLES+1 edges after release.
REQ-031 a_raw toggled every cycle for 50 cycles -> a never changes and a_chg stays 0 throughout.
